rolling_average_window: RTL



---
 rtl/rolling_average_window.sv | 118 +++++++++++
 1 files changed

// File: rtl/rolling_average_window.sv
// rolling_average_window: windowed sum/mean over the last 2**LOG2_DEPTH samples held in a private circular buffer.
// ROLLING_AVG_ROUND_EN defined selects a round-half-up mean; otherwise the mean truncates. Rev 1.0
`default_nettype none

module rolling_average_window #(
  parameter int DATA_W     = 5,
  parameter int LOG2_DEPTH = 3,
  localparam int SUM_W     = DATA_W + LOG2_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_clear,
  output logic                  o_valid,
  output logic [SUM_W-1:0]      o_sum,
  output logic [DATA_W-1:0]     o_avg,
  output logic                  o_full,
  output logic [LOG2_DEPTH:0]   o_fill
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int PTR_W  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int HIST_N = 1 << PTR_W;
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(DEPTH);
`ifdef ROLLING_AVG_ROUND_EN
  localparam logic [SUM_W-1:0]    RND      = SUM_W'(DEPTH / 2);
`else
  localparam logic [SUM_W-1:0]    RND      = '0;
`endif

  typedef enum logic {FILLING = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DATA_W-1:0]     avg_q, avg_d;
  logic [LOG2_DEPTH:0]   fill_q, fill_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic                  wr_en;

  logic [DATA_W-1:0]     hist_q [HIST_N];
  logic [DATA_W-1:0]     w_expire;
  logic [SUM_W-1:0]      w_sum_new;
  logic [SUM_W-1:0]      w_sum_rnd;

  // While filling, the slot under the pointer is stale (or never written) and must not be subtracted.
  assign w_expire  = (state_q == FULL) ? hist_q[ptr_q] : '0;
  assign w_sum_new = sum_q + SUM_W'(i_data) - SUM_W'(w_expire);
  assign w_sum_rnd = w_sum_new + RND;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    fill_d  = fill_q;
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    if (i_clear) begin
      state_d = FILLING;
      sum_d   = '0;
      avg_d   = '0;
      fill_d  = '0;
      ptr_d   = '0;
    end else if (i_valid) begin
      wr_en   = 1'b1;
      valid_d = 1'b1;
      sum_d   = w_sum_new;
      avg_d   = w_sum_rnd[SUM_W-1:LOG2_DEPTH];
      ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      case (state_q)
        FILLING: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_MAX - 1'b1) begin
            state_d = FULL;
          end
        end
        FULL:    fill_d = fill_q;
        default: state_d = FILLING;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILLING;
      sum_q   <= '0;
      avg_q   <= '0;
      fill_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      fill_q  <= fill_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      hist_q[ptr_q] <= i_data;
    end
  end

  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_avg   = avg_q;
  assign o_full  = (state_q == FULL);
  assign o_fill  = fill_q;

endmodule

`default_nettype wire
